// File: rtl/fifo_fwft.sv
// fifo_fwft: synchronous first-word-fall-through FIFO.
// The head word is presented on dout whenever empty is low. Flags and level
// come only from registered state, so they never depend combinationally on
// wr_en or rd_en.
// Optional build macro: FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow
// flags and the err_clear input.
module fifo_fwft #(
    parameter int unsigned FIFO_DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned ALMOST_FULL_LEVEL  = 12,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
    localparam int unsigned AW                = $clog2(FIFO_DEPTH),
    localparam int unsigned LW                = AW + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] din,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] dout,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [LW-1:0]              level
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                       err_clear,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]              level_q, level_d;
    logic                       wr_accept;
    logic                       rd_accept;

    // Status flags and head-of-queue data from registered state only
    always_comb begin
        full         = (32'(level_q) == FIFO_DEPTH);
        empty        = (level_q == '0);
        almost_full  = (32'(level_q) >= ALMOST_FULL_LEVEL);
        almost_empty = (32'(level_q) <= ALMOST_EMPTY_LEVEL);
        level        = level_q;
        dout         = mem_q[rd_ptr_q];
    end

    // Accept decisions and next pointer/occupancy values
    always_comb begin
        wr_accept = wr_en && !full;
        rd_accept = rd_en && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_accept && !rd_accept) begin
            level_d = level_q + LW'(1);
        end else if (rd_accept && !wr_accept) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a new error wins over err_clear in the same cycle
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Error flag registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: self-checking bench for fifo_fwft using a queue reference model.
// Build macro FIFO_ERR_FLAGS_EN (if defined for the RTL) enables error-flag checks.
module tb_fifo_fwft;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 12;
    localparam int unsigned AEL   = 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, empty, almost_empty;
    logic [DW-1:0] dout;
    logic [LW-1:0] level;
`ifdef FIFO_ERR_FLAGS_EN
    logic err_clear = 1'b0;
    logic overflow, underflow;
    logic exp_ovf = 1'b0;
    logic exp_unf = 1'b0;
`endif

    fifo_fwft #(
        .FIFO_DATA_WIDTH   (DW),
        .FIFO_DEPTH        (DEPTH),
        .ALMOST_FULL_LEVEL (AFL),
        .ALMOST_EMPTY_LEVEL(AEL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .din         (din),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .almost_empty(almost_empty),
        .level       (level)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .err_clear   (err_clear),
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clock = ~clock;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [DW-1:0] model_q[$];

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the queue model
    task automatic check_all(input string tag);
        int unsigned n;
        n = model_q.size();
        cmp({tag, ":level"}, DW'(level), DW'(n));
        cmp({tag, ":empty"}, DW'(empty), DW'(n == 0));
        cmp({tag, ":full"}, DW'(full), DW'(n == DEPTH));
        cmp({tag, ":almost_full"}, DW'(almost_full), DW'(n >= AFL));
        cmp({tag, ":almost_empty"}, DW'(almost_empty), DW'(n <= AEL));
        if (n != 0) cmp({tag, ":dout"}, dout, model_q[0]);
`ifdef FIFO_ERR_FLAGS_EN
        cmp({tag, ":overflow"}, DW'(overflow), DW'(exp_ovf));
        cmp({tag, ":underflow"}, DW'(underflow), DW'(exp_unf));
`endif
    endtask

    // One clock cycle: drive after the falling edge, check mid-low phase,
    // advance the model at the rising edge, return at the next falling edge.
    task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
        bit was_full, was_empty;
        wr_en = w;
        din   = d;
        rd_en = r;
        #1;
        check_all(tag);
        @(posedge clock);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
`ifdef FIFO_ERR_FLAGS_EN
        if (err_clear) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end
        if (w && was_full) exp_ovf = 1'b1;
        if (r && was_empty) exp_unf = 1'b1;
`endif
        if (r && !was_empty) void'(model_q.pop_front());
        if (w && !was_full) model_q.push_back(d);
        @(negedge clock);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check_all("reset");

        // Three consecutive writes, no reads
        cycle("w1", 1'b1, 32'h11111111, 1'b0);
        #1;
        cmp("first_word_dout", dout, 32'h11111111);
        cmp("first_word_empty", DW'(empty), '0);
        cycle("w2", 1'b1, 32'h22222222, 1'b0);
        cycle("w3", 1'b1, 32'h33333333, 1'b0);
        #1;
        cmp("three_level", DW'(level), 32'd3);
        cmp("three_dout", dout, 32'h11111111);

        // Fill 0..15, overfill with 0xDEAD, drain
        do_reset();
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, DW'(i), 1'b0);
        #1;
        cmp("fill_full", DW'(full), 32'd1);
        cycle("overfill", 1'b1, 32'hDEAD, 1'b0);
        #1;
        cmp("overfill_level", DW'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            #1;
            cmp("drain_order", dout, DW'(i));
            cycle("drain", 1'b0, '0, 1'b1);
        end
        #1;
        cmp("drain_empty", DW'(empty), 32'd1);

        // Steady state at level 5 across pointer wrap
        for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) cycle("stream", 1'b1, $urandom, 1'b1);
        #1;
        cmp("stream_level", DW'(level), 32'd5);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 11; i++) cycle("tofull", 1'b1, $urandom, 1'b0);
        cycle("full_rw", 1'b1, 32'hBAD0BAD0, 1'b1);
        #1;
        cmp("full_rw_level", DW'(level), 32'd15);
        for (int i = 0; i < 15; i++) cycle("toempty", 1'b0, '0, 1'b1);
        cycle("empty_rw", 1'b1, 32'hC0FFEE01, 1'b1);
        #1;
        cmp("empty_rw_level", DW'(level), 32'd1);
        cmp("empty_rw_dout", dout, 32'hC0FFEE01);

        // Asynchronous reset mid-stream at level 7
        for (int i = 0; i < 6; i++) cycle("to7", 1'b1, 32'hA0000000 + DW'(i), 1'b0);
        #1;
        cmp("pre_reset_level", DW'(level), 32'd7);
        #1;
        reset = 1'b0;
        #1;
        cmp("async_reset_level", DW'(level), '0);
        cmp("async_reset_empty", DW'(empty), 32'd1);
        model_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        @(negedge clock);
        reset = 1'b1;
        cycle("post_reset_w", 1'b1, 32'h5EED5EED, 1'b0);
        #1;
        cmp("post_reset_dout", dout, 32'h5EED5EED);
        cycle("post_reset_r", 1'b0, '0, 1'b1);

        // Randomized traffic with biased read/write mix
        for (int i = 0; i < 400; i++) begin
            int unsigned wp;
            wp = (i < 200) ? 70 : 30;
            cycle("rand", ($urandom_range(99) < wp), $urandom, ($urandom_range(99) < 50));
        end

`ifdef FIFO_ERR_FLAGS_EN
        // Sticky error flags and clear
        do_reset();
        for (int i = 0; i < 16; i++) cycle("ef_fill", 1'b1, $urandom, 1'b0);
        cycle("ef_ovf", 1'b1, 32'hDEAD, 1'b0);
        #1;
        cmp("overflow_set", DW'(overflow), 32'd1);
        cycle("ef_hold", 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) cycle("ef_drain", 1'b0, '0, 1'b1);
        cycle("ef_unf", 1'b0, '0, 1'b1);
        #1;
        cmp("underflow_set", DW'(underflow), 32'd1);
        cmp("overflow_sticky", DW'(overflow), 32'd1);
        err_clear = 1'b1;
        cycle("ef_clr", 1'b0, '0, 1'b0);
        err_clear = 1'b0;
        #1;
        cmp("ovf_cleared", DW'(overflow), '0);
        cmp("unf_cleared", DW'(underflow), '0);
        err_clear = 1'b1;
        cycle("ef_setprio", 1'b0, '0, 1'b1);
        err_clear = 1'b0;
        #1;
        cmp("set_priority", DW'(underflow), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_fwft.md
# fifo_fwft

Synchronous first-word-fall-through FIFO forming the far end of the `rd_en`/`empty` and `wr_en`/`full` handshakes used by the FM radio datapath stages (filters, demodulator, decimators). Producers write when `full` is low; consumers sample `dout` combinationally whenever `empty` is low and pulse `rd_en` to pop. One instance sits between each pair of adjacent stages, so its flag timing defines the throughput of the chain.

## Interface
- `FIFO_DATA_WIDTH`, 32, width of each stored word
- `FIFO_DEPTH`, 16, number of entries; power of two, minimum 4
- `ALMOST_FULL_LEVEL`, 12, `almost_full` asserts when `level >= ALMOST_FULL_LEVEL`
- `ALMOST_EMPTY_LEVEL`, 2, `almost_empty` asserts when `level <= ALMOST_EMPTY_LEVEL`

- `clock`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted at 0), synchronous deassert by system
- `wr_en`  input  1  write request from producer
- `din`  input  FIFO_DATA_WIDTH  write data, sampled with `wr_en`
- `full`  output  1  no free entry
- `almost_full`  output  1  level threshold flag
- `rd_en`  input  1  pop request from consumer
- `dout`  output  FIFO_DATA_WIDTH  head-of-queue word, valid whenever `empty` is 0
- `empty`  output  1  no stored entry
- `almost_empty`  output  1  level threshold flag
- `level`  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH

## Operation
- Storage: FIFO_DEPTH-entry array, write pointer, read pointer, occupancy counter; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accepted write: `wr_en && !full` -> store `din` at write pointer, increment write pointer.
- Accepted read: `rd_en && !empty` -> increment read pointer.
- `level` += 1 on accepted write only, -= 1 on accepted read only, unchanged on both or neither.
- `wr_en` while `full` is ignored, even if `rd_en` is high in the same cycle (no write-through when full). Stored data and pointers unchanged by the rejected write.
- `rd_en` while `empty` is ignored, even if `wr_en` is high in the same cycle; the written word is stored and appears at `dout` next cycle.
- `dout` = array[read pointer], combinational from registered pointer; holds the stale last value when `empty` (value undefined to consumers).
- Flags are combinational from registered `level`: `full = (level == FIFO_DEPTH)`, `empty = (level == 0)`.
- Reset (any time, including mid-burst): pointers and `level` to 0, in-flight data discarded; array contents are not cleared.

## Timing
- Reset values: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `level`=0, `dout` unspecified.
- Write-to-read latency: word accepted at edge N is visible on `dout` with `empty`=0 after edge N (usable in cycle N+1).
- Flags and `level` change only on clock edges or on reset assertion; they never depend combinationally on `wr_en`/`rd_en`.
- Sustained throughput: one write and one read per cycle when 0 < level < FIFO_DEPTH.
- `full` clears in the cycle after an accepted read at full; `empty` clears in the cycle after an accepted write at empty.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined: adds outputs `overflow` and `underflow` (1 bit each) and input `err_clear` (1 bit). `overflow` sets sticky on any `wr_en && full`; `underflow` sets sticky on any `rd_en && empty`; both clear on `err_clear` (set has priority in the same cycle) or reset (reset value 0).
- Not defined: those ports do not exist; rejected requests are silently dropped as above. Datapath behaviour identical in both builds.

## Test plan
- Reset then write 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, no reads -> `empty` falls one cycle after first write, `dout`=0x11111111, `level`=3.
- Fill 16 words 0..15 with DEPTH=16 -> `almost_full` at level 12, `full` at level 16; 17th write (0xDEAD) ignored; drain 16 reads returns 0..15 in order, then `empty`=1.
- Simultaneous `wr_en`/`rd_en` every cycle for 40 cycles from level 5 -> `level` stays 5, output order preserved across pointer wrap.
- At `full`, assert `wr_en`+`rd_en` together -> read accepted, write rejected, `level`=15; at `empty`, both together -> `level`=1, `dout`=written word next cycle.
- Assert `reset`=0 mid-stream at level 7 -> `level`=0, `empty`=1 immediately (asynchronous); next write/read pair returns the new word, not old data.
- With `FIFO_ERR_FLAGS_EN`: write while full -> `overflow`=1 next cycle and stays; read while empty -> `underflow`=1; pulse `err_clear` -> both 0.
